// File: rtl/knn_classifier.sv
// -----------------------------------------------------------------------------
// knn_classifier
//
// k-nearest-neighbour engine. Accepts one test point, then a stream of
// labelled data points. Each data point goes through a two-stage distance
// pipeline and is then insertion-sorted into a K-entry register list of
// (distance, label) pairs. After the last point has drained, a majority
// vote over the list runs one class per cycle and the winner is offered
// on the result handshake.
//
// Handshakes: every channel follows valid/ready. A transfer happens on a
// rising clock edge where both valid and ready are high. A producer holds
// valid and its payload until the transfer. The engine's ready and valid
// outputs are registered and never depend combinationally on the other side.
//
// Build option: define KNN_MANHATTAN_EN to use the L1 distance |dx|+|dy|.
// Without it the distance is squared Euclidean, dx*dx + dy*dy. Both builds
// have the same pipeline depth, latency and DIST_W.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   tp_valid/ready     test point channel, tp_point = {x, y}
//   dp_valid/ready     data point channel, dp_point = {x, y}, dp_label,
//                      dp_last marks the final point of the set
//   res_valid/ready    result channel: res_label (winner), res_count
//                      (votes for the winner), res_dist (nearest distance)
//   busy               high whenever the FSM is not in IDLE
//   state_dbg          current FSM state encoding (debug observation)
// -----------------------------------------------------------------------------
module knn_classifier #(
  parameter int COORD_W    = 16,
  parameter int K          = 4,
  parameter int LABEL_W    = 8,
  parameter int NBR_LABELS = 4,
  parameter int DIST_W     = 2*COORD_W+3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tp_valid,
  output logic                     tp_ready,
  input  logic [2*COORD_W-1:0]     tp_point,
  input  logic                     dp_valid,
  output logic                     dp_ready,
  input  logic [2*COORD_W-1:0]     dp_point,
  input  logic [LABEL_W-1:0]       dp_label,
  input  logic                     dp_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [LABEL_W-1:0]       res_label,
  output logic [$clog2(K+1)-1:0]   res_count,
  output logic [DIST_W-1:0]        res_dist,
  output logic                     busy,
  output logic [2:0]               state_dbg
);

  localparam int CNT_W = $clog2(K+1);
  localparam int VI_W  = $clog2(NBR_LABELS+1);
  localparam int EXT_W = DIST_W - COORD_W - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_VOTE   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state;
  assign state_dbg = state;

  logic tp_hs;
  logic dp_hs;
  assign tp_hs = tp_valid && tp_ready;
  assign dp_hs = dp_valid && dp_ready;

  // Registered test point
  logic [COORD_W-1:0] tp_x;
  logic [COORD_W-1:0] tp_y;

  logic [COORD_W-1:0] dp_x;
  logic [COORD_W-1:0] dp_y;
  assign dp_x = dp_point[2*COORD_W-1:COORD_W];
  assign dp_y = dp_point[COORD_W-1:0];

  // ---------------------------------------------------------------------------
  // Distance pipeline
  //   stage 1: signed differences, one bit wider than a coordinate so that
  //            the full range (-32768 vs 32767 at 16 bits) cannot wrap.
  //   stage 2: combined distance.
  // ---------------------------------------------------------------------------
  logic                      s1_valid;
  logic signed [COORD_W:0]   s1_dx;
  logic signed [COORD_W:0]   s1_dy;
  logic [LABEL_W-1:0]        s1_label;

  logic                      s2_valid;
  logic [DIST_W-1:0]         s2_dist;
  logic [LABEL_W-1:0]        s2_label;

  logic signed [DIST_W-1:0]  dx_ext;
  logic signed [DIST_W-1:0]  dy_ext;
  logic [DIST_W-1:0]         dist_calc;

  assign dx_ext = {{EXT_W{s1_dx[COORD_W]}}, s1_dx};
  assign dy_ext = {{EXT_W{s1_dy[COORD_W]}}, s1_dy};

`ifdef KNN_MANHATTAN_EN
  logic signed [DIST_W-1:0] abs_dx;
  logic signed [DIST_W-1:0] abs_dy;
  assign abs_dx    = dx_ext[DIST_W-1] ? -dx_ext : dx_ext;
  assign abs_dy    = dy_ext[DIST_W-1] ? -dy_ext : dy_ext;
  assign dist_calc = abs_dx + abs_dy;
`else
  logic signed [DIST_W-1:0] sq_dx;
  logic signed [DIST_W-1:0] sq_dy;
  // Squares fit comfortably in DIST_W, so the truncated signed products
  // are exact and non-negative.
  assign sq_dx     = dx_ext * dx_ext;
  assign sq_dy     = dy_ext * dy_ext;
  assign dist_calc = sq_dx + sq_dy;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_label <= '0;
      s2_valid <= 1'b0;
      s2_dist  <= '0;
      s2_label <= '0;
    end else begin
      s1_valid <= dp_hs;
      if (dp_hs) begin
        s1_dx    <= {dp_x[COORD_W-1], dp_x} - {tp_x[COORD_W-1], tp_x};
        s1_dy    <= {dp_y[COORD_W-1], dp_y} - {tp_y[COORD_W-1], tp_y};
        s1_label <= dp_label;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_dist  <= dist_calc;
        s2_label <= s1_label;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sorted neighbour list. Valid entries are always packed at the top in
  // ascending distance order, so "less" below is monotonic: false for the
  // nearer entries, true from the insertion slot downwards. Strict '>' keeps
  // equal distances in arrival order.
  // ---------------------------------------------------------------------------
  logic [DIST_W-1:0]   list_dist  [K];
  logic [LABEL_W-1:0]  list_label [K];
  logic [K-1:0]        list_valid;

  logic [K-1:0]        less;
  logic [DIST_W-1:0]   nxt_dist   [K];
  logic [LABEL_W-1:0]  nxt_label  [K];
  logic [K-1:0]        nxt_valid;

  always_comb begin
    less      = '0;
    nxt_valid = list_valid;
    for (int i = 0; i < K; i++) begin
      nxt_dist[i]  = list_dist[i];
      nxt_label[i] = list_label[i];
      less[i]      = !list_valid[i] || (list_dist[i] > s2_dist);
    end
    if (less[0]) begin
      nxt_dist[0]  = s2_dist;
      nxt_label[0] = s2_label;
      nxt_valid[0] = 1'b1;
    end
    for (int i = 1; i < K; i++) begin
      if (less[i-1]) begin
        // At or below the insertion slot: shift down by one
        nxt_dist[i]  = list_dist[i-1];
        nxt_label[i] = list_label[i-1];
        nxt_valid[i] = list_valid[i-1];
      end else if (less[i]) begin
        nxt_dist[i]  = s2_dist;
        nxt_label[i] = s2_label;
        nxt_valid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      list_valid <= '0;
      for (int i = 0; i < K; i++) begin
        list_dist[i]  <= '1;
        list_label[i] <= '0;
      end
    end else if (tp_hs) begin
      list_valid <= '0;
      for (int i = 0; i < K; i++) begin
        list_dist[i] <= '1;
      end
    end else if (s2_valid) begin
      list_valid <= nxt_valid;
      for (int i = 0; i < K; i++) begin
        list_dist[i]  <= nxt_dist[i];
        list_label[i] <= nxt_label[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vote: number of valid entries carrying the class currently being counted
  // ---------------------------------------------------------------------------
  logic [VI_W-1:0]    vote_idx;
  logic [CNT_W-1:0]   vote_cnt;
  logic [LABEL_W-1:0] best_label;
  logic [CNT_W-1:0]   best_count;
  logic [1:0]         drain_cnt;

  always_comb begin
    vote_cnt = '0;
    for (int i = 0; i < K; i++) begin
      if (list_valid[i] && (list_label[i] == LABEL_W'(vote_idx))) begin
        vote_cnt = vote_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs.
  // DRAIN waits three cycles so the last point has left both pipeline stages
  // and been inserted. VOTE counts one class per cycle, then spends one more
  // cycle latching the result, so res_valid rises NBR_LABELS+4 edges after
  // the edge that accepted dp_last.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tp_ready   <= 1'b1;
      dp_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_label  <= '0;
      res_count  <= '0;
      res_dist   <= '0;
      busy       <= 1'b0;
      tp_x       <= '0;
      tp_y       <= '0;
      drain_cnt  <= '0;
      vote_idx   <= '0;
      best_label <= '0;
      best_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tp_hs) begin
            tp_x     <= tp_point[2*COORD_W-1:COORD_W];
            tp_y     <= tp_point[COORD_W-1:0];
            tp_ready <= 1'b0;
            dp_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (dp_hs && dp_last) begin
            dp_ready  <= 1'b0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd2) begin
            vote_idx   <= '0;
            best_label <= '0;
            best_count <= '0;
            state      <= S_VOTE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_VOTE: begin
          if (vote_idx == VI_W'(NBR_LABELS)) begin
            res_label <= best_label;
            res_count <= best_count;
            res_dist  <= list_dist[0];
            res_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            // Strictly greater only: ties keep the lower class
            if (vote_cnt > best_count) begin
              best_label <= LABEL_W'(vote_idx);
              best_count <= vote_cnt;
            end
            vote_idx <= vote_idx + VI_W'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            tp_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          tp_ready <= 1'b1;
          dp_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_classifier.sv
// -----------------------------------------------------------------------------
// tb_knn_classifier
//
// Bench for knn_classifier at default parameters. A table of hand-computed
// sets is applied first, followed by hand-written sequences for reset,
// backpressure and abort, and then randomized sets checked against a
// reference model. The model sorts the whole point set by distance and
// counts labels with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_knn_classifier;

  localparam int COORD_W    = 16;
  localparam int K          = 4;
  localparam int LABEL_W    = 8;
  localparam int NBR_LABELS = 4;
  localparam int DIST_W     = 2*COORD_W+3;
  localparam int CNT_W      = $clog2(K+1);
  localparam int RES_W      = LABEL_W + CNT_W + DIST_W;
  localparam int MAXP       = 16;

  // ---------------------------------------------------------------- signals
  logic                  clk;
  logic                  rst;
  logic                  tp_valid;
  logic                  tp_ready;
  logic [2*COORD_W-1:0]  tp_point;
  logic                  dp_valid;
  logic                  dp_ready;
  logic [2*COORD_W-1:0]  dp_point;
  logic [LABEL_W-1:0]    dp_label;
  logic                  dp_last;
  logic                  res_valid;
  logic                  res_ready;
  logic [LABEL_W-1:0]    res_label;
  logic [CNT_W-1:0]      res_count;
  logic [DIST_W-1:0]     res_dist;
  logic                  busy;
  logic [2:0]            state_dbg;

  knn_classifier #(
    .COORD_W(COORD_W), .K(K), .LABEL_W(LABEL_W),
    .NBR_LABELS(NBR_LABELS), .DIST_W(DIST_W)
  ) dut (
    .clk(clk), .rst(rst),
    .tp_valid(tp_valid), .tp_ready(tp_ready), .tp_point(tp_point),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_point(dp_point),
    .dp_label(dp_label), .dp_last(dp_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_label(res_label), .res_count(res_count), .res_dist(res_dist),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ------------------------------------------------------ clock/reset block
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------- bookkeeping
  int n_vec = 0;
  int n_err = 0;
  logic [RES_W-1:0] exp_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    int                     tx;
    int                     ty;
    int                     n;
    logic [7:0][15:0]       px;
    logic [7:0][15:0]       py;
    logic [7:0][7:0]        lb;
    int                     e_label;
    int                     e_count;
    longint                 e_dist;
  } vec_t;

  vec_t tbl[4];

  task automatic add_pt(input int v, input int x, input int y, input int l);
    tbl[v].px[tbl[v].n] = 16'(x);
    tbl[v].py[tbl[v].n] = 16'(y);
    tbl[v].lb[tbl[v].n] = 8'(l);
    tbl[v].n++;
  endtask

  // ---------------------------------------------------- current point set
  int cur_tx, cur_ty, cur_n;
  int cur_px[MAXP];
  int cur_py[MAXP];
  int cur_lb[MAXP];

  // --------------------------------------------------------- reference model
  function automatic longint model_dist(input int i);
    longint dx, dy;
    dx = longint'(cur_px[i] - cur_tx);
    dy = longint'(cur_py[i] - cur_ty);
`ifdef KNN_MANHATTAN_EN
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return dx + dy;
`else
    return dx*dx + dy*dy;
`endif
  endfunction

  // Pick the K nearest (earliest point wins a tie), then majority vote over
  // in-range labels with ties going to the lowest label.
  function automatic logic [RES_W-1:0] model_result();
    longint d[MAXP];
    bit     used[MAXP];
    int     cnt[NBR_LABELS];
    int     sel, best, bl, bc;
    longint nearest;
    for (int i = 0; i < MAXP; i++) used[i] = 1'b0;
    for (int c = 0; c < NBR_LABELS; c++) cnt[c] = 0;
    for (int i = 0; i < cur_n; i++) d[i] = model_dist(i);
    sel = (cur_n < K) ? cur_n : K;
    nearest = 0;
    for (int s = 0; s < sel; s++) begin
      best = -1;
      for (int i = 0; i < cur_n; i++)
        if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
      used[best] = 1'b1;
      if (s == 0) nearest = d[best];
      if (cur_lb[best] < NBR_LABELS) cnt[cur_lb[best]]++;
    end
    bl = 0;
    bc = 0;
    for (int c = 0; c < NBR_LABELS; c++)
      if (cnt[c] > bc) begin
        bc = cnt[c];
        bl = c;
      end
    return {LABEL_W'(bl), CNT_W'(bc), DIST_W'(nearest)};
  endfunction

  // ----------------------------------------------------------- driver tasks
  task automatic send_tp(output bit ok);
    bit hs;
    ok = 1'b0;
    tp_point = {cur_tx[15:0], cur_ty[15:0]};
    tp_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      hs = tp_ready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    tp_valid = 1'b0;
    tp_point = $urandom;
  endtask

  task automatic send_dp(input int i, input bit last, output bit ok);
    bit hs;
    ok = 1'b0;
    dp_point = {cur_px[i][15:0], cur_py[i][15:0]};
    dp_label = 8'(cur_lb[i]);
    dp_last  = last;
    dp_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      hs = dp_ready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    dp_valid = 1'b0;
    dp_last  = 1'b0;
    dp_point = $urandom;
    dp_label = 8'($urandom);
  endtask

  // Full transaction: test point, the set, result check, optional
  // backpressure, result handshake.
  task automatic run_set(input logic [RES_W-1:0] exp, input int gap_max,
                         input int hold, input bit noise);
    bit ok, got;
    int last_cyc;
    logic [RES_W-1:0] e;
    logic [LABEL_W-1:0] e_label;
    logic [CNT_W-1:0]   e_count;
    logic [DIST_W-1:0]  e_dist;
    exp_q.push_back(exp);

    send_tp(ok);
    if (!ok) timeout("tp_accept");
    check("stream_dp_ready", dp_ready, 1);
    check("stream_busy", busy, 1);

    last_cyc = cyc;
    for (int i = 0; i < cur_n; i++) begin
      int gap;
      gap = $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          tp_valid = 1'($urandom);
          tp_point = $urandom;
        end
        @(posedge clk); #1;
      end
      tp_valid = 1'b0;
      send_dp(i, (i == cur_n - 1), ok);
      if (!ok) timeout("dp_accept");
      last_cyc = cyc;
    end
    check("dp_ready_drop", dp_ready, 0);

    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (noise) dp_valid = 1'($urandom);
      @(posedge clk); #1;
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    dp_valid = 1'b0;
    if (!got) timeout("res_valid");
    check("latency", cyc - last_cyc, NBR_LABELS + 4);

    e = exp_q.pop_front();
    {e_label, e_count, e_dist} = e;
    check("res_label", res_label, e_label);
    check("res_count", res_count, e_count);
    check("res_dist", res_dist, e_dist);

    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_tp_ready", tp_ready, 0);
      check("hold_label", res_label, e_label);
      check("hold_count", res_count, e_count);
      check("hold_dist", res_dist, e_dist);
    end

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_tp_ready", tp_ready, 1);
    check("post_busy", busy, 0);
    check("post_label", res_label, e_label);
  endtask

  task automatic load_tbl(input int v);
    cur_tx = tbl[v].tx;
    cur_ty = tbl[v].ty;
    cur_n  = tbl[v].n;
    for (int i = 0; i < tbl[v].n; i++) begin
      cur_px[i] = int'($signed(tbl[v].px[i]));
      cur_py[i] = int'($signed(tbl[v].py[i]));
      cur_lb[i] = int'(tbl[v].lb[i]);
    end
  endtask

  function automatic logic [RES_W-1:0] tbl_exp(input int v);
    return {LABEL_W'(tbl[v].e_label), CNT_W'(tbl[v].e_count), DIST_W'(tbl[v].e_dist)};
  endfunction

  // ------------------------------------------------------------------- test
  initial begin
    bit ok;
    // Table contents
    for (int v = 0; v < 4; v++) begin
      tbl[v].n  = 0;
      tbl[v].tx = 0;
      tbl[v].ty = 0;
      tbl[v].px = '0;
      tbl[v].py = '0;
      tbl[v].lb = '0;
    end
    // Basic: list d1 L1, d1 L2, d2 L3, d4 L2 -> class 2 with 2 votes
    add_pt(0, 1, 0, 1); add_pt(0, 0, 2, 2); add_pt(0, 3, 0, 1);
    add_pt(0, 1, 1, 3); add_pt(0, 5, 5, 2); add_pt(0, 0, 1, 2);
    tbl[0].e_label = 2; tbl[0].e_count = 2; tbl[0].e_dist = 1;
    // Vote tie between classes 0 and 1 -> lower class wins
    add_pt(1, 2, 0, 0); add_pt(1, 1, 0, 1); add_pt(1, 3, 0, 0); add_pt(1, 0, 4, 1);
    tbl[1].e_label = 0; tbl[1].e_count = 2; tbl[1].e_dist = 1;
    // Short set: only two valid entries vote
    add_pt(2, 0, 3, 3); add_pt(2, 4, 0, 3);
    tbl[2].e_label = 3; tbl[2].e_count = 2;
    // Extremes: opposite corners of the coordinate range
    tbl[3].tx = -32768; tbl[3].ty = -32768;
    add_pt(3, 32767, 32767, 1);
    tbl[3].e_label = 1; tbl[3].e_count = 1;
`ifdef KNN_MANHATTAN_EN
    tbl[0].e_dist = 1; tbl[1].e_dist = 1; tbl[2].e_dist = 3;
    tbl[3].e_dist = 64'd131070;
`else
    tbl[2].e_dist = 9;
    tbl[3].e_dist = 64'd8589672450;
`endif

    // Reset with random inputs
    rst       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tp_valid  = 1'($urandom);
      tp_point  = $urandom;
      dp_valid  = 1'($urandom);
      dp_point  = $urandom;
      dp_label  = 8'($urandom);
      dp_last   = 1'($urandom);
      res_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    check("rst_tp_ready", tp_ready, 1);
    check("rst_dp_ready", dp_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_label", res_label, 0);
    check("rst_res_count", res_count, 0);
    check("rst_res_dist", res_dist, 0);
    tp_valid = 1'b0; dp_valid = 1'b0; dp_last = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors: back-to-back points; the first one also backpressured
    for (int v = 0; v < 4; v++) begin
      load_tbl(v);
      run_set(tbl_exp(v), 0, (v == 0) ? 10 : 0, 1'b0);
    end

    // Abort mid-stream via asynchronous reset
    load_tbl(0);
    send_tp(ok);
    if (!ok) timeout("abort_tp_accept");
    for (int i = 0; i < 3; i++) begin
      send_dp(i, 1'b0, ok);
      if (!ok) timeout("abort_dp_accept");
    end
    #2 rst = 1'b0;
    #1;
    check("abort_tp_ready", tp_ready, 1);
    check("abort_dp_ready", dp_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_res_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    load_tbl(1);
    run_set(tbl_exp(1), 1, 2, 1'b0);

    // Randomized sets against the reference model
    for (int r = 0; r < 30; r++) begin
      cur_n = $urandom_range(1, 10);
      if (r % 5 == 0) begin
        cur_tx = int'($signed(16'($urandom)));
        cur_ty = int'($signed(16'($urandom)));
      end else begin
        cur_tx = $urandom_range(0, 20) - 10;
        cur_ty = $urandom_range(0, 20) - 10;
      end
      for (int i = 0; i < cur_n; i++) begin
        if (r % 5 == 0) begin
          cur_px[i] = int'($signed(16'($urandom)));
          cur_py[i] = int'($signed(16'($urandom)));
        end else begin
          cur_px[i] = $urandom_range(0, 20) - 10;
          cur_py[i] = $urandom_range(0, 20) - 10;
        end
        cur_lb[i] = $urandom_range(0, 5);
      end
      run_set(model_result(), 2, $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
